tpu_stream_core: RTL and testbench



---
 rtl/tpu_stream_core_if.sv | 29 ++
 rtl/tpu_stream_core.sv | 201 ++++++++++++++++++++
 tb/tb_tpu_stream_core.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_stream_core_if.sv
// Bundles the serial link and host-side handshake signals of tpu_stream_core.
// Latency: none (wires only).
// Backpressure: tx_accept from the consumer stalls data_out_z/tx_ready.
interface tpu_stream_core_if #(
    parameter int LANES = 1
);
    logic [LANES-1:0] data_in_x;
    logic [LANES-1:0] data_in_y;
    logic             load_en;
    logic             init;
    logic             tx_accept;
    logic [LANES-1:0] data_out_z;
    logic             tx_ready;
    logic             loaded;
    logic             busy;
    logic             done;

    // Host/link side: drives streams and control, observes status.
    modport master (
        output data_in_x, data_in_y, load_en, init, tx_accept,
        input  data_out_z, tx_ready, loaded, busy, done
    );

    // Core side.
    modport slave (
        input  data_in_x, data_in_y, load_en, init, tx_accept,
        output data_out_z, tx_ready, loaded, busy, done
    );
endinterface

// File: rtl/tpu_stream_core.sv
// Deserialises signed NxN A and B, computes C = A x B with one MAC per cycle, serialises saturated C.
// Latency: N^3 compute cycles after init; first output beat valid N^3+1 cycles after init acceptance.
// Backpressure: an output beat advances only when tx_ready && tx_accept; otherwise data_out_z holds.
module tpu_stream_core #(
    parameter int D_W   = 8,
    parameter int N     = 2,
    parameter int LANES = 1,
    parameter int OUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    tpu_stream_core_if.slave  io
);
    localparam int NE    = N * N;
    localparam int EPB   = D_W / LANES;     // input beats per element
    localparam int OPB   = OUT_W / LANES;   // output beats per element
    localparam int ACC_W = 2 * D_W + $clog2(N);
    localparam int IB_W  = (EPB > 1) ? $clog2(EPB) : 1;
    localparam int OB_W  = (OPB > 1) ? $clog2(OPB) : 1;
    localparam int E_W   = $clog2(NE);
    localparam int IX_W  = $clog2(N);
    localparam int MSB_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t state, state_n;

    logic signed [D_W-1:0] a_mem [NE];
    logic signed [D_W-1:0] b_mem [NE];
    logic [OUT_W-1:0]      c_mem [NE];

    logic [IB_W-1:0]  in_beat;
    logic [E_W-1:0]   in_elem;
    logic [IX_W-1:0]  ci, cj, ck;
    logic [ACC_W-1:0] acc;
    logic [OB_W-1:0]  out_beat;
    logic [E_W-1:0]   out_elem;
    logic             loaded_q;
    logic             done_q;

    logic beat_fire, last_in_beat, last_in_elem, load_last;
    logic k_last, j_last, i_last, comp_last;
    logic tx_fire, out_last, init_acc;

    assign beat_fire    = io.load_en && (state == S_IDLE || state == S_LOAD);
    assign last_in_beat = (in_beat == IB_W'(EPB - 1));
    assign last_in_elem = (in_elem == E_W'(NE - 1));
    assign load_last    = beat_fire && last_in_beat && last_in_elem;
    assign init_acc     = (state == S_READY) && io.init;

    assign k_last    = (ck == IX_W'(N - 1));
    assign j_last    = (cj == IX_W'(N - 1));
    assign i_last    = (ci == IX_W'(N - 1));
    assign comp_last = (state == S_COMPUTE) && k_last && j_last && i_last;

    assign tx_fire  = (state == S_DRAIN) && io.tx_accept;
    assign out_last = tx_fire && (out_beat == OB_W'(OPB - 1)) && (out_elem == E_W'(NE - 1));

    // Next element values while shifting in MSB-first.
    logic [D_W-1:0] a_next, b_next;
    generate
        if (D_W == LANES) begin : g_shift_full
            assign a_next = io.data_in_x;
            assign b_next = io.data_in_y;
        end else begin : g_shift_part
            assign a_next = {a_mem[in_elem][D_W-LANES-1:0], io.data_in_x};
            assign b_next = {b_mem[in_elem][D_W-LANES-1:0], io.data_in_y};
        end
    endgenerate

    // MAC datapath: A[i][k] * B[k][j], accumulator restarts at k == 0.
    logic [E_W-1:0]          a_idx, b_idx, c_idx;
    logic signed [2*D_W-1:0] prod;
    logic [ACC_W-1:0]        acc_base, sum;
    logic [OUT_W-1:0]        sat_val;

    assign a_idx    = E_W'(int'(ci) * N + int'(ck));
    assign b_idx    = E_W'(int'(ck) * N + int'(cj));
    assign c_idx    = E_W'(int'(ci) * N + int'(cj));
    assign prod     = a_mem[a_idx] * b_mem[b_idx];
    assign acc_base = (ck == '0) ? '0 : acc;
    assign sum      = acc_base + {{(ACC_W - 2*D_W){prod[2*D_W-1]}}, prod};

    // Clamp the full-precision sum into the signed OUT_W range.
    generate
        if (OUT_W > ACC_W) begin : g_sat_ext
            assign sat_val = {{(OUT_W - ACC_W){sum[ACC_W-1]}}, sum};
        end else if (OUT_W == ACC_W) begin : g_sat_eq
            assign sat_val = sum;
        end else begin : g_sat_clip
            logic [ACC_W-OUT_W:0] upper;
            assign upper = sum[ACC_W-1:OUT_W-1];
            always_comb begin
                sat_val = sum[OUT_W-1:0];
                if (!((&upper) || (~|upper)))
                    sat_val = sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                           : {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    endgenerate

    // Output beat selection, MSB-first within each C element.
    logic [MSB_W-1:0] out_msb;
    logic [OUT_W-1:0] c_elem;
    assign out_msb = MSB_W'(OUT_W - 1 - int'(out_beat) * LANES);
    assign c_elem  = c_mem[out_elem];

    assign io.data_out_z = (state == S_DRAIN) ? c_elem[out_msb -: LANES] : '0;
    assign io.tx_ready   = (state == S_DRAIN);
    assign io.busy       = (state == S_COMPUTE) || (state == S_DRAIN);
    assign io.loaded     = loaded_q;
    assign io.done       = done_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic; init has priority over load_en in READY.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (beat_fire) state_n = S_LOAD;
            S_LOAD:    if (load_last) state_n = S_READY;
            S_READY:   if (io.init)   state_n = S_COMPUTE;
            S_COMPUTE: if (comp_last) state_n = S_DRAIN;
            S_DRAIN:   if (out_last)  state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Counters, accumulator and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_beat  <= '0;
            in_elem  <= '0;
            ci       <= '0;
            cj       <= '0;
            ck       <= '0;
            acc      <= '0;
            out_beat <= '0;
            out_elem <= '0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= out_last;
            if (load_last)     loaded_q <= 1'b1;
            else if (init_acc) loaded_q <= 1'b0;

            if (beat_fire) begin
                if (last_in_beat) begin
                    in_beat <= '0;
                    in_elem <= last_in_elem ? '0 : in_elem + 1'b1;
                end else begin
                    in_beat <= in_beat + 1'b1;
                end
            end

            if (state == S_COMPUTE) begin
                acc <= sum;
                if (k_last) begin
                    ck <= '0;
                    if (j_last) begin
                        cj <= '0;
                        ci <= i_last ? '0 : ci + 1'b1;
                    end else begin
                        cj <= cj + 1'b1;
                    end
                end else begin
                    ck <= ck + 1'b1;
                end
            end

            if (tx_fire) begin
                if (out_beat == OB_W'(OPB - 1)) begin
                    out_beat <= '0;
                    out_elem <= (out_elem == E_W'(NE - 1)) ? '0 : out_elem + 1'b1;
                end else begin
                    out_beat <= out_beat + 1'b1;
                end
            end
        end
    end

    // Matrix storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            a_mem[in_elem] <= a_next;
            b_mem[in_elem] <= b_next;
        end
        if (state == S_COMPUTE && k_last)
            c_mem[c_idx] <= sat_val;
    end
endmodule

// File: tb/tb_tpu_stream_core.sv
// Bench for tpu_stream_core: two instances (N=2/LANES=1/OUT_W=16 and N=3/LANES=4/OUT_W=20).
// Latency: checks N^3+1 cycles from init acceptance to first valid beat.
// Backpressure: drives random tx_accept and checks that held beats stay stable.
module tb_tpu_stream_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic [3:0] dx = '0, dy = '0;
    logic       load_en = 1'b0, init = 1'b0, tx_accept = 1'b0;
    logic [3:0] z;
    logic       tx_ready, loaded, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int ma [9];
    int mb [9];

    tpu_stream_core_if #(.LANES(1)) if0 ();
    tpu_stream_core_if #(.LANES(4)) if1 ();

    tpu_stream_core dut0 (.clk(clk), .rst(rst), .io(if0.slave));
    tpu_stream_core #(.D_W(8), .N(3), .LANES(4), .OUT_W(20)) dut1 (.clk(clk), .rst(rst), .io(if1.slave));

    assign if0.data_in_x = dx[0];
    assign if0.data_in_y = dy[0];
    assign if0.load_en   = load_en & ~sel;
    assign if0.init      = init & ~sel;
    assign if0.tx_accept = tx_accept & ~sel;
    assign if1.data_in_x = dx;
    assign if1.data_in_y = dy;
    assign if1.load_en   = load_en & sel;
    assign if1.init      = init & sel;
    assign if1.tx_accept = tx_accept & sel;

    assign z        = sel ? if1.data_out_z : {3'b000, if0.data_out_z};
    assign tx_ready = sel ? if1.tx_ready : if0.tx_ready;
    assign loaded   = sel ? if1.loaded   : if0.loaded;
    assign busy     = sel ? if1.busy     : if0.busy;
    assign done     = sel ? if1.done     : if0.done;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain matrix product with clamping to the signed ow range.
    function automatic int model_c(int i, int j, int n, int ow);
        int s  = 0;
        int hi = (1 << (ow - 1)) - 1;
        int lo = -(1 << (ow - 1));
        for (int k = 0; k < n; k++) s += ma[i*n + k] * mb[k*n + j];
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    task automatic load_mats(int n, int lanes, int gap_pct, int init_beat);
        int bpe   = 8 / lanes;
        int total = n * n * bpe;
        int mask  = (1 << lanes) - 1;
        int e, sh;
        for (int b = 0; b < total; b++) begin
            while ($urandom_range(99) < gap_pct) begin
                load_en = 1'b0;
                init    = 1'b0;
                dx = 4'($urandom);
                dy = 4'($urandom);
                step();
            end
            e  = b / bpe;
            sh = 8 - lanes * (b % bpe + 1);
            dx = 4'((ma[e] >> sh) & mask);
            dy = 4'((mb[e] >> sh) & mask);
            load_en = 1'b1;
            init    = (b == init_beat);
            if (b == total - 1) check("loaded_before_last", 32'(loaded), 32'd0);
            step();
        end
        load_en = 1'b0;
        init    = 1'b0;
        check("loaded", 32'(loaded), 32'd1);
        check("busy_after_load", 32'(busy), 32'd0);
    endtask

    task automatic ready_noise(int cycles);
        for (int c = 0; c < cycles; c++) begin
            load_en = 1'($urandom);
            dx = 4'($urandom);
            dy = 4'($urandom);
            step();
        end
        load_en = 1'b0;
        check("ready_hold_loaded", 32'(loaded), 32'd1);
        check("ready_hold_busy", 32'(busy), 32'd0);
    endtask

    task automatic start_compute(int n, bit with_load);
        int cnt;
        init    = 1'b1;
        load_en = with_load;
        step();
        init    = 1'b0;
        load_en = 1'b0;
        check("busy_compute", 32'(busy), 32'd1);
        check("loaded_cleared", 32'(loaded), 32'd0);
        cnt = 1;
        while (!tx_ready && cnt < 2000) begin
            step();
            cnt++;
        end
        check("latency", 32'(cnt), 32'(n * n * n + 1));
    endtask

    task automatic drain_check(int n, int lanes, int ow, int acc_pct, bit noise, int rst_beat);
        int total = n * n * ow / lanes;
        int bpe   = ow / lanes;
        int got   = 0;
        int guard = 0;
        int idx;
        logic [31:0] elem = '0;
        logic [31:0] mask;
        logic [3:0]  prev_z = '0;
        bit held = 1'b0;
        bit acc;
        mask = (32'd1 << ow) - 32'd1;
        while (got < total) begin
            guard++;
            if (guard > 4000) begin
                check("drain_timeout", 32'(got), 32'(total));
                break;
            end
            check("tx_ready_drain", 32'(tx_ready), 32'd1);
            if (held) check("hold_z", 32'(z), 32'(prev_z));
            if (got == rst_beat) begin
                rst       = 1'b1;
                tx_accept = 1'b0;
                step();
                rst = 1'b0;
                check("rst_tx_ready", 32'(tx_ready), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_loaded", 32'(loaded), 32'd0);
                check("rst_z", 32'(z), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                return;
            end
            acc = ($urandom_range(99) < acc_pct);
            tx_accept = acc;
            if (noise) begin
                load_en = 1'($urandom);
                dx = 4'($urandom);
                dy = 4'($urandom);
            end
            if (acc) begin
                elem = (elem << lanes) | 32'(z);
                got++;
                if (got % bpe == 0) begin
                    idx = got / bpe - 1;
                    check("c_elem", elem, 32'(model_c(idx / n, idx % n, n, ow)) & mask);
                    elem = '0;
                end
            end
            held   = !acc;
            prev_z = z;
            step();
        end
        tx_accept = 1'b0;
        load_en   = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("idle_tx_ready", 32'(tx_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_z", 32'(z), 32'd0);
        step();
        check("done_once", 32'(done), 32'd0);
    endtask

    task automatic set_basic();
        for (int i = 0; i < 4; i++) begin
            ma[i] = i + 1;
            mb[i] = i + 5;
        end
    endtask

    task automatic full_run2(int gap_pct, int acc_pct, bit noise);
        load_mats(2, 1, gap_pct, -1);
        start_compute(2, 1'b0);
        drain_check(2, 1, 16, acc_pct, noise, -1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        check("rst0_tx_ready", 32'(tx_ready), 32'd0);
        check("rst0_loaded", 32'(loaded), 32'd0);
        check("rst0_busy", 32'(busy), 32'd0);
        check("rst0_done", 32'(done), 32'd0);
        check("rst0_z", 32'(z), 32'd0);
        sel = 1'b1;
        check("rst1_tx_ready", 32'(tx_ready), 32'd0);
        check("rst1_busy", 32'(busy), 32'd0);
        sel = 1'b0;
        rst = 1'b0;
        step();

        // Basic multiply.
        set_basic();
        full_run2(0, 100, 1'b0);

        // Positive saturation.
        for (int i = 0; i < 4; i++) begin ma[i] = -128; mb[i] = -128; end
        full_run2(0, 100, 1'b0);

        // Large negative, still in range.
        for (int i = 0; i < 4; i++) begin ma[i] = 127; mb[i] = -128; end
        full_run2(0, 100, 1'b0);

        // Gaps, init mid-load, noise in READY, init+load_en together, backpressure.
        set_basic();
        load_mats(2, 1, 40, 10);
        ready_noise(6);
        start_compute(2, 1'b1);
        drain_check(2, 1, 16, 50, 1'b1, -1);

        // Random matrices.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                ma[i] = int'($urandom_range(255)) - 128;
                mb[i] = int'($urandom_range(255)) - 128;
            end
            full_run2(25, 60, 1'b1);
        end

        // Reset in the middle of the drain, then a clean rerun.
        set_basic();
        load_mats(2, 1, 0, -1);
        start_compute(2, 1'b0);
        drain_check(2, 1, 16, 100, 1'b0, 20);
        full_run2(0, 100, 1'b0);

        // Wide lanes: identity times 1..9.
        sel = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ma[i] = (i % 4 == 0) ? 1 : 0;
            mb[i] = i + 1;
        end
        load_mats(3, 4, 0, -1);
        start_compute(3, 1'b0);
        drain_check(3, 4, 20, 70, 1'b0, -1);

        // Wide lanes with random signed data.
        for (int i = 0; i < 9; i++) begin
            ma[i] = int'($urandom_range(255)) - 128;
            mb[i] = int'($urandom_range(255)) - 128;
        end
        load_mats(3, 4, 30, 5);
        start_compute(3, 1'b0);
        drain_check(3, 4, 20, 50, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
